// File: rtl/dpi_stream_dispatcher.sv
// dpi_stream_dispatcher: maps packet flow keys to stream ids and sequences load_state/char/eop strobes for the matcher bank
module dpi_stream_dispatcher #(
  parameter int N_REGEX = 8,
  parameter int DEPTH = 64,
  parameter int LOAD_GAP = 2,
  parameter int EOP_LAT = 3,
  localparam int SID_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [31:0]        in_flow_key,
  input  logic [N_REGEX-1:0] in_enable,
  output logic [7:0]         char_in,
  output logic               char_in_vld,
  output logic [SID_W-1:0]   stream_id,
  output logic               new_stream_id,
  output logic               load_state,
  output logic               eop,
  output logic [N_REGEX-1:0] enable,
  output logic               busy,
  output logic [15:0]        pkt_count,
  output logic [15:0]        evict_count,
  output logic [15:0]        drop_count
);
  typedef enum logic [2:0] {IDLE, LOOKUP, LOAD, WAIT, STREAM, DRAIN, EOP} state_t;
  state_t state, nxt;
  logic [31:0] key_r;
  logic [N_REGEX-1:0] en_cap;
  logic [31:0] tkey [DEPTH];
  logic [DEPTH-1:0] tval;
  logic [SID_W-1:0] victim, hit_idx, free_idx, slot;
  logic hit, free;
  logic [7:0] cnt;
  logic sop_beat, eop_beat;
  assign sop_beat = state == IDLE && in_valid && in_sop;
  assign eop_beat = state == STREAM && in_valid && in_eop;
  assign load_state = state == LOAD;
  assign eop = state == EOP;
  assign busy = state != IDLE;
  assign in_ready = rst_n && (state == STREAM || (state == IDLE && !in_sop));
  // Descending scan so the lowest matching / lowest free index wins.
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    free = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (tval[i] && tkey[i] == key_r) begin
        hit = 1'b1;
        hit_idx = SID_W'(i);
      end
      if (!tval[i]) begin
        free = 1'b1;
        free_idx = SID_W'(i);
      end
    end
  end
  assign slot = hit ? hit_idx : (free ? free_idx : victim);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // WAIT plus the first STREAM cycle (before the registered byte lands) form the LOAD_GAP idle cycles.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = sop_beat ? LOOKUP : IDLE;
      LOOKUP:  nxt = LOAD;
      LOAD:    nxt = WAIT;
      WAIT:    nxt = cnt == 8'(LOAD_GAP - 2) ? STREAM : WAIT;
      STREAM:  nxt = eop_beat ? DRAIN : STREAM;
      DRAIN:   nxt = cnt == 8'(EOP_LAT - 1) ? EOP : DRAIN;
      EOP:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r <= '0;
      en_cap <= '0;
      tval <= '0;
      victim <= '0;
      cnt <= '0;
      char_in <= '0;
      char_in_vld <= 1'b0;
      stream_id <= '0;
      new_stream_id <= 1'b0;
      enable <= '0;
      pkt_count <= '0;
      evict_count <= '0;
      drop_count <= '0;
    end else begin
      if (sop_beat) begin
        key_r <= in_flow_key;
        en_cap <= in_enable;
      end
      if (state == IDLE && in_valid && !in_sop) drop_count <= drop_count + 16'd1;
      if (state == LOOKUP) begin
        stream_id <= slot;
        new_stream_id <= !hit;
        enable <= en_cap;
        if (!hit) tval[slot] <= 1'b1;
        if (!hit && !free) begin
          evict_count <= evict_count + 16'd1;
          victim <= victim == SID_W'(DEPTH - 1) ? '0 : victim + 1'b1;
        end
      end
      char_in_vld <= state == STREAM && in_valid;
      if (state == STREAM && in_valid) char_in <= in_data;
      cnt <= (state == LOAD || eop_beat) ? '0 : (state == WAIT || state == DRAIN) ? cnt + 8'd1 : cnt;
      if (state == EOP) begin
        pkt_count <= pkt_count + 16'd1;
        stream_id <= '0;
        new_stream_id <= 1'b0;
        enable <= '0;
      end
    end
  end
  always_ff @(posedge clk)
    if (state == LOOKUP && !hit) tkey[slot] <= key_r;
endmodule

// File: tb/tb_dpi_stream_dispatcher.sv
// tb_dpi_stream_dispatcher: vector table, corner sequences and random traffic against a key-table reference model
module tb_dpi_stream_dispatcher;
  logic clk = 0, rst_n = 0;
  logic [7:0] in_data = 0;
  logic in_valid = 0, in_sop = 0, in_eop = 0;
  logic [31:0] in_flow_key = 0;
  logic [7:0] in_enable = 0;
  logic in_ready, char_in_vld, new_stream_id, load_state, eop, busy;
  logic [7:0] char_in, enable;
  logic [5:0] stream_id;
  logic [15:0] pkt_count, evict_count, drop_count;
  always #5 clk = ~clk;
  dpi_stream_dispatcher dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_sop(in_sop), .in_eop(in_eop), .in_flow_key(in_flow_key), .in_enable(in_enable),
    .char_in(char_in), .char_in_vld(char_in_vld), .stream_id(stream_id),
    .new_stream_id(new_stream_id), .load_state(load_state), .eop(eop), .enable(enable),
    .busy(busy), .pkt_count(pkt_count), .evict_count(evict_count), .drop_count(drop_count)
  );
  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  // reference model: associative table of flow keys
  logic [31:0] m_key [64];
  bit m_v [64];
  int m_vp, m_evict, m_pkts, m_drops;
  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_v[i] = 0;
    m_vp = 0; m_evict = 0; m_pkts = 0; m_drops = 0;
  endtask
  task automatic m_lookup(input logic [31:0] k, output int sid, output bit nw);
    sid = -1;
    for (int i = 0; i < 64; i++) if (m_v[i] && m_key[i] == k) begin sid = i; break; end
    nw = sid < 0;
    if (nw) begin
      for (int i = 0; i < 64; i++) if (!m_v[i]) begin sid = i; break; end
      if (sid < 0) begin
        sid = m_vp;
        m_vp = (m_vp + 1) % 64;
        m_evict++;
      end
      m_key[sid] = k;
      m_v[sid] = 1;
    end
  endtask
  // monitor
  int ld_cyc, first_c, last_c, eop_cyc, n_load, n_char, n_eop;
  logic [5:0] ld_sid;
  logic ld_new;
  logic [7:0] ld_en;
  bit in_pkt, stab_bad, both_hi;
  logic [7:0] rx_q[$], tx_q[$];
  int sop_cyc;
  always @(negedge clk) begin
    if (load_state && eop) both_hi = 1;
    if (load_state) begin
      n_load++; ld_cyc = cyc; ld_sid = stream_id; ld_new = new_stream_id; ld_en = enable;
      first_c = -1; rx_q.delete(); in_pkt = 1; stab_bad = 0;
    end else if (in_pkt && (stream_id !== ld_sid || enable !== ld_en || new_stream_id !== ld_new))
      stab_bad = 1;
    if (char_in_vld) begin
      n_char++;
      if (first_c < 0) first_c = cyc;
      last_c = cyc;
      rx_q.push_back(char_in);
    end
    if (eop) begin n_eop++; eop_cyc = cyc; in_pkt = 0; end
    if (!rst_n) in_pkt = 0;
  end
  task automatic send(input logic [31:0] k, input logic [7:0] en, input int len, input int gap);
    int g;
    bit acc;
    tx_q.delete();
    for (int i = 0; i < len; i++) begin
      if (i > 0) while ($urandom_range(99) < gap) begin in_valid = 0; @(posedge clk); #1; end
      in_valid = 1; in_sop = i == 0; in_eop = i == len - 1;
      in_data = 8'($urandom);
      in_flow_key = i == 0 ? k : 32'h0;
      in_enable = i == 0 ? en : 8'h0;
      if (i == 0) sop_cyc = cyc;
      tx_q.push_back(in_data);
      g = 0;
      do begin @(negedge clk); acc = in_ready; @(posedge clk); #1; g++; end while (!acc && g < 100);
      if (!acc) begin chk("accept_timeout", 0, 1); break; end
    end
    in_valid = 0; in_sop = 0; in_eop = 0;
  endtask
  task automatic pkt(input logic [31:0] k, input logic [7:0] en, input int len, input int gap);
    int es, n0, w;
    bit enw, same;
    m_lookup(k, es, enw);
    n0 = n_eop;
    send(k, en, len, gap);
    @(negedge clk);
    chk("ready_low_after_eop_beat", in_ready, 0);
    w = 0;
    while (n_eop == n0 && w < 60) begin @(negedge clk); w++; end
    chk("eop_count", n_eop - n0, 1);
    m_pkts++;
    chk("sid", ld_sid, es);
    chk("new", ld_new, enw);
    chk("enable", ld_en, en);
    chk("load_latency", ld_cyc - sop_cyc, 2);
    chk("first_char_gap", first_c - ld_cyc, 3);
    chk("eop_latency", eop_cyc - last_c, 3);
    same = rx_q.size() == tx_q.size();
    if (same) foreach (tx_q[i]) if (rx_q[i] !== tx_q[i]) same = 0;
    chk("bytes", same, 1);
    chk("held_stable", stab_bad, 0);
    @(negedge clk);
    chk("pkt_count", pkt_count, 16'(m_pkts));
    chk("evict_count", evict_count, 16'(m_evict));
    chk("idle_after", {busy, new_stream_id, stream_id}, 0);
  endtask
  task automatic do_reset();
    rst_n = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask
  typedef struct {
    logic [31:0] key;
    logic [7:0] en;
    int len;
    int gap;
    int sid;
    bit nw;
  } vec_t;
  vec_t vt [6];
  logic [31:0] hist [$];
  initial begin
    int w, n0, nc, ne;
    logic [31:0] k;
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    int w, nl, nc, ne;
    logic [31:0] k;
    vt[0] = '{32'hA5A5_0001, 8'h81, 4, 0, 0, 1};
    vt[1] = '{32'hA5A5_0001, 8'h0F, 2, 30, 0, 0};
    vt[2] = '{32'hA5A5_0002, 8'hF0, 3, 30, 1, 1};
    vt[3] = '{32'hA5A5_0001, 8'h3C, 5, 40, 0, 0};
    vt[4] = '{32'hA5A5_0002, 8'hFF, 1, 0, 1, 0};
    vt[5] = '{32'h1234_5678, 8'h01, 2, 20, 2, 1};
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", {load_state, eop, char_in_vld, busy, new_stream_id, in_ready}, 0);
    chk("rst_ids", {stream_id, enable, char_in}, 0);
    chk("rst_counts", {pkt_count, evict_count, drop_count}, 0);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      pkt(vt[i].key, vt[i].en, vt[i].len, vt[i].gap);
      chk("vec_sid", ld_sid, vt[i].sid);
      chk("vec_new", ld_new, vt[i].nw);
      if (i == 0) chk("t1_eop_cycle", eop_cyc - sop_cyc, 11);
    end
    // non-sop bytes in IDLE are dropped
    nl = n_load; nc = n_char; ne = n_eop;
    @(posedge clk); #1;
    in_valid = 1; in_sop = 0; in_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drop_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 0;
    m_drops += 3;
    @(negedge clk);
    chk("drop_count", drop_count, 16'(m_drops));
    chk("drop_no_strobes", {n_load - nl, n_char - nc, n_eop - ne}, 0);
    // single-byte packet amid gapped traffic
    pkt(32'hA5A5_0002, 8'h5A, 1, 50);
    pkt(32'hA5A5_0003, 8'hC3, 6, 50);
    // reset in the middle of STREAM
    do_reset();
    pkt(32'hDEAD_0006, 8'h11, 2, 0);
    pkt(32'hDEAD_0006, 8'h22, 2, 0);
    chk("t6_hit", ld_new, 0);
    @(posedge clk); #1;
    in_valid = 1; in_sop = 1; in_flow_key = 32'hDEAD_0006; in_enable = 8'h33; in_data = 8'h01;
    w = 0;
    do begin @(negedge clk); w++; end while (!in_ready && w < 20);
    chk("t6_reach_stream", in_ready, 1);
    @(posedge clk); #1;
    in_sop = 0; in_flow_key = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("t6_rst_strobes", {load_state, eop, char_in_vld, busy, new_stream_id, in_ready}, 0);
    chk("t6_rst_ids", {stream_id, enable, char_in}, 0);
    chk("t6_rst_counts", {pkt_count, evict_count, drop_count}, 0);
    in_valid = 0;
    ne = n_eop;
    m_reset();
    @(posedge clk); #1 rst_n = 1;
    chk("t6_no_eop", n_eop - ne, 0);
    pkt(32'hDEAD_0006, 8'h44, 3, 0);
    chk("t6_miss_after_reset", {ld_new, ld_sid}, {1'b1, 6'd0});
    // fill, evict and wrap the victim pointer
    do_reset();
    for (int i = 0; i < 129; i++) begin
      k = {8'hE0, 8'($urandom), 16'(i)};
      hist.push_back(k);
      pkt(k, 8'($urandom), $urandom_range(1, 3), 20);
      if (i == 64) chk("evict_65th", {ld_new, ld_sid, evict_count}, {1'b1, 6'd0, 16'd1});
      if (i == 65) chk("evict_66th", {ld_new, ld_sid, evict_count}, {1'b1, 6'd1, 16'd2});
      if (i == 128) chk("victim_wrap", {ld_new, ld_sid, evict_count}, {1'b1, 6'd0, 16'd65});
    end
    // random mix of resident keys, evicted keys and fresh keys
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(2) == 0) k = {8'hF1, 8'($urandom), 16'(i)};
      else k = hist[$urandom_range(hist.size() - 1)];
      hist.push_back(k);
      pkt(k, 8'($urandom), $urandom_range(1, 6), $urandom_range(0, 50));
    end
    chk("load_eop_overlap", both_hi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
